// File: rtl/credit_fifo_vc_pkg.sv
// Shared widths and types for the virtual-channel credit FIFO.
package credit_fifo_vc_pkg;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth);
    endfunction

    localparam int NUM_CH_DEF = 4;
    localparam int DEPTH_DEF  = 16;

    typedef logic [ch_w(NUM_CH_DEF)-1:0] ch_idx_t;
    typedef logic [cnt_w(DEPTH_DEF):0]   cnt_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last grant.
module rr_arbiter
    import credit_fifo_vc_pkg::*;
#(
    parameter int N = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       req,
    input  logic               advance,
    output logic [N-1:0]       gnt,
    output logic [ch_w(N)-1:0] idx,
    output logic               any
);

    localparam int IW = ch_w(N);

    logic [IW-1:0] ptr;
    int            j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int i = 1; i <= N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= IW'(N - 1);
        end else if (advance && any) begin
            ptr <= idx;
        end
    end

endmodule

// File: rtl/credit_fifo_vc.sv
// Multi-channel credit/valid FIFO with private per-channel partitions
// and round-robin output arbitration.
module credit_fifo_vc
    import credit_fifo_vc_pkg::*;
#(
    parameter  int DATA_WIDTH   = 8,
    parameter  int DEPTH        = 16,
    parameter  int NUM_CH       = 4,
    parameter  int DOWN_CREDITS = 4,
    localparam int CH_W         = ch_w(NUM_CH),
    localparam int CW           = cnt_w(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_valid,
    input  logic [CH_W-1:0]          push_ch,
    input  logic [DATA_WIDTH-1:0]    push_data,
    output logic [NUM_CH-1:0]        push_credit,
    output logic                     pop_valid,
    output logic [CH_W-1:0]          pop_ch,
    output logic [DATA_WIDTH-1:0]    pop_data,
    input  logic [NUM_CH-1:0]        pop_credit,
    output logic [NUM_CH*(CW+1)-1:0] ch_count,
    output logic [NUM_CH-1:0]        overflow_err,
    output logic [NUM_CH-1:0]        credit_err
);

    localparam int DW = $clog2(DOWN_CREDITS + 1);

    logic [DATA_WIDTH-1:0] mem [NUM_CH*DEPTH];
    logic [NUM_CH-1:0]     eligible;
    logic [NUM_CH-1:0]     gnt;
    logic [NUM_CH-1:0]     push_hit;
    logic [NUM_CH*CW-1:0]  wr_lo;
    logic [NUM_CH*CW-1:0]  rd_lo;
    logic [CH_W-1:0]       g_idx;
    logic                  g_any;
    logic                  push_ok;

    assign push_ok = push_valid && (int'(push_ch) < NUM_CH);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [CW:0]   cnt;
        logic [CW:0]   wp;
        logic [CW:0]   rp;
        logic [CW:0]   pend;
        logic [DW-1:0] dc;
        logic          issue;
        logic          launch;
        logic          sel;
        logic          pc_q;
        logic          ovf_q;
        logic          cerr_q;

        assign sel         = push_ok && (push_ch == CH_W'(c));
        assign push_hit[c] = sel && (cnt != (CW+1)'(DEPTH));
        assign launch      = gnt[c];
        assign issue       = (pend != '0);
        assign eligible[c] = (cnt != '0) && (dc != '0);

        assign wr_lo[c*CW +: CW]         = wp[CW-1:0];
        assign rd_lo[c*CW +: CW]         = rp[CW-1:0];
        assign ch_count[c*(CW+1) +: CW+1] = cnt;
        assign push_credit[c]            = pc_q;
        assign overflow_err[c]           = ovf_q;
        assign credit_err[c]             = cerr_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt    <= '0;
                wp     <= '0;
                rp     <= '0;
                pend   <= (CW+1)'(DEPTH);
                dc     <= DW'(DOWN_CREDITS);
                pc_q   <= 1'b0;
                ovf_q  <= 1'b0;
                cerr_q <= 1'b0;
            end else begin
                pc_q <= issue;
                pend <= pend - (CW+1)'(issue) + (CW+1)'(launch);
                if (push_hit[c]) wp <= wp + 1'b1;
                if (launch) rp <= rp + 1'b1;
                if (push_hit[c] && !launch) cnt <= cnt + 1'b1;
                if (!push_hit[c] && launch) cnt <= cnt - 1'b1;
                if (sel && !push_hit[c]) ovf_q <= 1'b1;
                // a return that coincides with a launch cancels out
                if (launch && !pop_credit[c]) begin
                    dc <= dc - 1'b1;
                end else if (!launch && pop_credit[c]) begin
                    if (dc == DW'(DOWN_CREDITS)) cerr_q <= 1'b1;
                    else dc <= dc + 1'b1;
                end
            end
        end
    end

    rr_arbiter #(
        .N(NUM_CH)
    ) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (eligible),
        .advance(1'b1),
        .gnt    (gnt),
        .idx    (g_idx),
        .any    (g_any)
    );

    always_ff @(posedge clk) begin
        if (|push_hit) begin
            mem[{push_ch, wr_lo[push_ch*CW +: CW]}] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_valid <= 1'b0;
            pop_ch    <= '0;
            pop_data  <= '0;
        end else begin
            pop_valid <= g_any;
            if (g_any) begin
                pop_ch   <= g_idx;
                pop_data <= mem[{g_idx, rd_lo[g_idx*CW +: CW]}];
            end
        end
    end

endmodule
